rename_arbiter: RTL

- Shares the single rename port and two read ports of the register alias table (RAT) between two decode lanes (lane 0, lane 1).
- Per cycle: grants at most one lane using round-robin priority, drives the RAT ports from the granted micro-op, and captures the returned physical tags in a one-entry output register.
- The output register feeds dispatch through a valid/ready handshake.
- Stalls cleanly when the RAT free list is exhausted or dispatch back-pressures.

---
 rtl/rename_arbiter.sv | 162 ++++++++++++++++
 1 files changed

// File: rtl/rename_arbiter.sv
// rename_arbiter: round-robin share of one RAT rename port and two read
// ports between two decode lanes, with a one-entry slot toward dispatch.
// Ports:
//   clk, rst            clock and async active-high reset
//   req_*               per-lane micro-op requests, req_ready is consumed
//   rat_*               RAT rename port and read ports
//   out_*               renamed micro-op, valid/ready to dispatch
//   stall_free_cnt      cycles blocked on an empty free list
//   grant_cnt0/1        micro-ops renamed per lane
module rename_arbiter #(
  parameter int NUM_ARCH_REGS = 8,
  parameter int NUM_PHYS_REGS = 16,
  parameter int CNT_W = 16,
  localparam int AW = $clog2(NUM_ARCH_REGS),
  localparam int PW = $clog2(NUM_PHYS_REGS)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [1:0]       req_valid,
  output logic [1:0]       req_ready,
  input  logic [1:0]       req_has_dest,
  input  logic [2*AW-1:0]  req_dest,
  input  logic [2*AW-1:0]  req_src1,
  input  logic [2*AW-1:0]  req_src2,
  output logic             rat_rename_in_valid,
  output logic [AW-1:0]    rat_arch_dest,
  input  logic             rat_rename_out_valid,
  input  logic [PW-1:0]    rat_phys_dest,
  output logic [AW-1:0]    rat_src1,
  output logic [AW-1:0]    rat_src2,
  output logic             rat_read_valid,
  input  logic [PW-1:0]    rat_phys_src1,
  input  logic [PW-1:0]    rat_phys_src2,
  input  logic             rat_found1,
  input  logic             rat_found2,
  output logic             out_valid,
  input  logic             out_ready,
  output logic             out_lane,
  output logic             out_has_dest,
  output logic [PW-1:0]    out_pdest,
  output logic [PW-1:0]    out_psrc1,
  output logic [PW-1:0]    out_psrc2,
  output logic             out_rdy1,
  output logic             out_rdy2,
  output logic [CNT_W-1:0] stall_free_cnt,
  output logic [CNT_W-1:0] grant_cnt0,
  output logic [CNT_W-1:0] grant_cnt1
);

  typedef enum logic {EMPTY, FULL} state_t;

  state_t        state;
  logic          ptr;
  logic          cand;
  logic          cand_vld;
  logic          cand_hd;
  logic          slot_free;
  logic          fire;
  logic          blk;
  logic [AW-1:0] cand_dest;
  logic [AW-1:0] cand_s1;
  logic [AW-1:0] cand_s2;

  always_comb begin
    cand = 1'b0;
    unique case (req_valid)
      2'b11:   cand = ptr;
      2'b10:   cand = 1'b1;
      default: cand = 1'b0;
    endcase
  end

  assign cand_vld  = |req_valid;
  assign cand_hd   = cand_vld & req_has_dest[cand];
  assign slot_free = ~out_valid | out_ready;

  always_comb begin
    cand_dest = '0;
    cand_s1   = '0;
    cand_s2   = '0;
    if (cand_vld) begin
      if (cand) begin
        cand_dest = req_dest[2*AW-1:AW];
        cand_s1   = req_src1[2*AW-1:AW];
        cand_s2   = req_src2[2*AW-1:AW];
      end else begin
        cand_dest = req_dest[AW-1:0];
        cand_s1   = req_src1[AW-1:0];
        cand_s2   = req_src2[AW-1:0];
      end
    end
  end

  assign rat_arch_dest = cand_dest;
  assign rat_src1      = cand_s1;
  assign rat_src2      = cand_s2;
  assign rat_read_valid = slot_free & cand_vld;

  // The RAT commits whenever this is high and a tag is free,
  // so it is gated by slot_free to avoid leaking tags.
  assign rat_rename_in_valid = slot_free & cand_hd;

  assign fire = slot_free & cand_vld
              & (~cand_hd | rat_rename_out_valid);
  assign blk  = slot_free & cand_hd & ~rat_rename_out_valid;

  assign req_ready = {fire & cand, fire & ~cand};

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state          <= EMPTY;
      out_valid      <= 1'b0;
      out_lane       <= 1'b0;
      out_has_dest   <= 1'b0;
      out_pdest      <= '0;
      out_psrc1      <= '0;
      out_psrc2      <= '0;
      out_rdy1       <= 1'b0;
      out_rdy2       <= 1'b0;
      ptr            <= 1'b0;
      stall_free_cnt <= '0;
      grant_cnt0     <= '0;
      grant_cnt1     <= '0;
    end else begin
      unique case (state)
        EMPTY: begin
          if (fire) begin
            state     <= FULL;
            out_valid <= 1'b1;
          end
        end
        FULL: begin
          if (out_ready && !fire) begin
            state     <= EMPTY;
            out_valid <= 1'b0;
          end
        end
      endcase
      if (fire) begin
        out_lane     <= cand;
        out_has_dest <= cand_hd;
        out_pdest    <= cand_hd ? rat_phys_dest : '0;
        out_psrc1    <= rat_phys_src1;
        out_psrc2    <= rat_phys_src2;
        out_rdy1     <= rat_found1;
        out_rdy2     <= rat_found2;
        ptr          <= ~cand;
        if (cand) begin
          if (grant_cnt1 != '1)
            grant_cnt1 <= grant_cnt1 + 1'b1;
        end else begin
          if (grant_cnt0 != '1)
            grant_cnt0 <= grant_cnt0 + 1'b1;
        end
      end
      // Blocked lane keeps the pointer: no bypass.
      if (blk && stall_free_cnt != '1)
        stall_free_cnt <= stall_free_cnt + 1'b1;
    end
  end

endmodule
